s_axi_lite_regfile: RTL and testbench
=====================================

Name: s_axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file, successor to the fixed 4-register slave. Provides P_NUM_REGS word registers with WSTRB byte-lane merging and independent AW/W acceptance. Optional read-only status words are driven from fabric inputs. Out-of-range or read-only accesses return SLVERR. Sits between the AXI-Lite interconnect and user control/status logic.

Parameters:
P_S_AXI_DATA_WIDTH, 32, data width in bits; 32 or 64 only.
P_S_AXI_ADDR_WIDTH, 6, byte address width; must cover P_NUM_REGS words.
P_NUM_REGS, 16, number of word registers, 1..256.
P_RO_MASK, 0, P_NUM_REGS-bit mask; bit i=1 makes reg i read-only (sourced from I_RO_DATA).

Ports:
S_AXI_ACLK  in  1  clock; all logic on the rising edge.
S_AXI_ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  P_S_AXI_ADDR_WIDTH  write byte address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
S_AXI_WDATA  in  P_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  P_S_AXI_DATA_WIDTH/8  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
S_AXI_ARADDR  in  P_S_AXI_ADDR_WIDTH  read byte address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
S_AXI_RDATA  out  P_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
O_REG_DATA  out  P_NUM_REGS*P_S_AXI_DATA_WIDTH  flat RW register contents; reg i at slice i.
O_REG_WR  out  P_NUM_REGS  one-cycle pulse per register on committed write.
I_RO_DATA  in  P_NUM_REGS*P_S_AXI_DATA_WIDTH  read-only sources; only slices with P_RO_MASK=1 are used.

Behaviour:
- Reset (S_AXI_ARESET=1 at an edge): all registers 0, AW/W buffers empty, BVALID=0, RVALID=0, BRESP=RRESP=00, RDATA=0, O_REG_WR=0. Resetting mid-transaction discards it; no write commits.
- Word index = addr >> log2(P_S_AXI_DATA_WIDTH/8); low address bits ignored. Index >= P_NUM_REGS is out of range.
- Write path, flags aw_full and w_full:
  - AWREADY = ~aw_full & ~BVALID; WREADY = ~w_full & ~BVALID.
  - Each handshake latches address/data+strobe and sets its flag. AW and W may arrive in either order or in the same cycle.
  - Commit edge: the first edge with aw_full & w_full & ~BVALID.
    - In-range RW register: register updated per byte lane where WSTRB=1; O_REG_WR[i] pulses for exactly the cycle after commit; BRESP=00.
    - Out-of-range or RO register: no update, no pulse; BRESP=10.
    - Both flags clear; BVALID=1.
  - BVALID holds, with BRESP stable, until an edge with BREADY=1.
  - Minimum latency: AW+W handshake at edge t0, commit and BVALID at t1.
  - WSTRB=0 still commits: OKAY response, register unchanged, O_REG_WR still pulses.
- Read path:
  - ARREADY = ~RVALID.
  - On the AR handshake edge, RDATA/RRESP are registered and RVALID=1:
    - RW register: current register value.
    - RO register: I_RO_DATA slice sampled at that edge.
    - Out of range: RDATA=0, RRESP=10.
  - RVALID holds, with RDATA stable, until an edge with RREADY=1. The next AR is accepted at the earliest one cycle later.
- Simultaneous write commit and read of the same register on one edge: read returns the pre-write value.
- Read and write channels are fully independent; no ordering between them.
- AWPROT/ARPROT are ignored; no protection checks.

Test Plan:
- Reset, then AW(0x04)+W(0xDEADBEEF, strb 0xF) in the same cycle, BREADY=1 -> BVALID one edge later, BRESP=00, O_REG_WR=0x0002 for one cycle, reg1=0xDEADBEEF; AR 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
- W(0x11223344) issued 3 cycles before AW(0x08) -> commit on the edge after the AW handshake; reg2=0x11223344.
- Partial strobe: reg3=0xAABBCCDD, write 0x00000099 strb 0x1 -> reg3=0xAABBCC99.
- Write to 0x40 with P_NUM_REGS=16 -> BRESP=10, no O_REG_WR pulse; read 0x40 -> RDATA=0, RRESP=10.
- P_RO_MASK=0x0001, I_RO_DATA slice0=0xCAFE0001: read 0x00 -> 0xCAFE0001; write 0x00 -> BRESP=10, O_REG_DATA slice0 stays 0.
- Hold BREADY=0 for 5 cycles with a new AW/W pending -> AWREADY/WREADY stay low and BRESP stays stable; assert S_AXI_ARESET mid-hold -> BVALID=0 and all registers 0 next cycle.

Source files
------------

// File: rtl/s_axi_lite_regfile.sv
// AXI4-Lite slave register file: P_NUM_REGS word registers with byte-lane
// write merging, independent AW/W acceptance and optional read-only words
// sourced from fabric inputs. Out-of-range or read-only writes answer SLVERR.
module s_axi_lite_regfile #(
    parameter int                    P_S_AXI_DATA_WIDTH = 32,
    parameter int                    P_S_AXI_ADDR_WIDTH = 6,
    parameter int                    P_NUM_REGS         = 16,
    parameter logic [P_NUM_REGS-1:0] P_RO_MASK          = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [P_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [P_NUM_REGS*P_S_AXI_DATA_WIDTH-1:0] O_REG_DATA,
    output logic [P_NUM_REGS-1:0]                    O_REG_WR,
    input  logic [P_NUM_REGS*P_S_AXI_DATA_WIDTH-1:0] I_RO_DATA
);
    localparam int LP_DW       = P_S_AXI_DATA_WIDTH;
    localparam int LP_AW       = P_S_AXI_ADDR_WIDTH;
    localparam int LP_STRB_W   = LP_DW / 8;
    localparam int LP_ADDR_LSB = $clog2(LP_STRB_W);
    localparam logic [LP_AW-1:0] LP_NUM_REGS = LP_AW'(P_NUM_REGS);
    localparam logic [1:0] LP_OKAY   = 2'b00;
    localparam logic [1:0] LP_SLVERR = 2'b10;

    logic                             aw_full, w_full;
    logic [LP_AW-1:0]                 aw_addr_q;
    logic [LP_DW-1:0]                 w_data_q;
    logic [LP_STRB_W-1:0]             w_strb_q;
    logic [P_NUM_REGS-1:0][LP_DW-1:0] regs_q;
    logic [P_NUM_REGS-1:0]            reg_wr_q;
    logic                             bvalid_q, rvalid_q;
    logic [1:0]                       bresp_q, rresp_q;
    logic [LP_DW-1:0]                 rdata_q;

    logic [LP_AW-1:0]      aw_idx, ar_idx;
    logic                  aw_ro, aw_ok, ar_in_range, commit;
    logic [P_NUM_REGS-1:0] wr_sel;
    logic [LP_DW-1:0]      ar_word;

    // PROT inputs carry no meaning for this block.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = ~aw_full & ~bvalid_q;
    assign S_AXI_WREADY  = ~w_full & ~bvalid_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign O_REG_DATA    = regs_q;
    assign O_REG_WR      = reg_wr_q;

    // Word index drops the byte-offset bits of the address.
    assign aw_idx      = aw_addr_q >> LP_ADDR_LSB;
    assign ar_idx      = S_AXI_ARADDR >> LP_ADDR_LSB;
    assign ar_in_range = ar_idx < LP_NUM_REGS;
    assign commit      = aw_full & w_full & ~bvalid_q;
    assign aw_ok       = (aw_idx < LP_NUM_REGS) & ~aw_ro;

    // Decode the buffered write address into per-register write selects.
    always_comb begin
        aw_ro  = 1'b0;
        wr_sel = '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
            if (aw_idx == LP_AW'(i)) begin
                aw_ro     = P_RO_MASK[i];
                wr_sel[i] = commit & ~P_RO_MASK[i];
            end
        end
    end

    // Read mux: RO words come straight from the fabric, out-of-range reads 0.
    always_comb begin
        ar_word = '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
            if (ar_idx == LP_AW'(i))
                ar_word = P_RO_MASK[i] ? I_RO_DATA[i*LP_DW +: LP_DW] : regs_q[i];
        end
    end

    // Write channel: AW/W buffering, commit, B response and write pulses.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= LP_OKAY;
            reg_wr_q  <= '0;
        end else begin
            reg_wr_q <= '0;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= aw_ok ? LP_OKAY : LP_SLVERR;
                reg_wr_q <= wr_sel;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register storage: byte-lane merge of committed write data.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < P_NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    for (int b = 0; b < LP_STRB_W; b++) begin
                        if (w_strb_q[b])
                            regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read channel: register data/response on AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= LP_OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_in_range ? ar_word : '0;
            rresp_q  <= ar_in_range ? LP_OKAY : LP_SLVERR;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_axi_lite_regfile.sv
// Bench for s_axi_lite_regfile: table of write/read-back vectors plus
// hand-written sequences; B and R beats checked against scoreboard queues.
module tb_s_axi_lite_regfile;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0001;

    logic              S_AXI_ACLK = 1'b0;
    logic              S_AXI_ARESET;
    logic [AW-1:0]     S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID, S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA;
    logic [DW/8-1:0]   S_AXI_WSTRB;
    logic              S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID, S_AXI_BREADY;
    logic [AW-1:0]     S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID, S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID, S_AXI_RREADY;
    logic [NR*DW-1:0]  O_REG_DATA;
    logic [NR-1:0]     O_REG_WR;
    logic [NR*DW-1:0]  I_RO_DATA;

    s_axi_lite_regfile #(
        .P_S_AXI_DATA_WIDTH(DW), .P_S_AXI_ADDR_WIDTH(AW),
        .P_NUM_REGS(NR), .P_RO_MASK(RO)
    ) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .O_REG_DATA(O_REG_DATA), .O_REG_WR(O_REG_WR), .I_RO_DATA(I_RO_DATA)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic [1:0]      bresp;
        logic [NR-1:0]   wr;
        logic [DW-1:0]   rdata;
        logic [1:0]      rresp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    vec_t       vecs[9];
    logic [1:0] bq[$];
    rexp_t      rq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // Scoreboard: each B/R beat is compared when the DUT presents it with ready high.
    always @(negedge S_AXI_ACLK) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", S_AXI_BRESP, bq.pop_front());
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else begin
                rexp_t e;
                e = rq.pop_front();
                check("rdata", S_AXI_RDATA, e.data);
                check("rresp", S_AXI_RRESP, e.resp);
            end
        end
    end

    // Wait for the requested handshakes (valids already driven), bounded.
    task automatic drive_hs(input bit do_aw, input bit do_w, input bit do_ar);
        bit aw_d, w_d, ar_d;
        aw_d = !do_aw; w_d = !do_w; ar_d = !do_ar;
        for (int n = 0; n < 20 && !(aw_d && w_d && ar_d); n++) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_d = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_d  = 1'b1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_d = 1'b1;
            tick();
            if (aw_d) S_AXI_AWVALID = 1'b0;
            if (w_d)  S_AXI_WVALID  = 1'b0;
            if (ar_d) S_AXI_ARVALID = 1'b0;
        end
        if (!(aw_d && w_d && ar_d)) begin
            check("handshake_timeout", 0, 1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        end
    endtask

    // AW+W in the same cycle; B must appear exactly one edge after the handshake.
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, input logic [1:0] er,
                             input logic [NR-1:0] ewr);
        bq.push_back(er);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        drive_hs(1, 1, 0);
        tick();
        check("bvalid_latency", S_AXI_BVALID, 1);
        check("reg_wr_pulse", O_REG_WR, ewr);
        tick();
        check("reg_wr_clear", O_REG_WR, 0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er);
        rq.push_back('{ed, er});
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        drive_hs(0, 0, 1);
        tick();
    endtask

    initial begin
        vecs[0] = '{7'h04, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0002, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{7'h0C, 32'hAABBCCDD, 4'hF, 2'b00, 16'h0008, 32'hAABBCCDD, 2'b00};
        vecs[2] = '{7'h0C, 32'h00000099, 4'h1, 2'b00, 16'h0008, 32'hAABBCC99, 2'b00};
        vecs[3] = '{7'h40, 32'h12345678, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
        vecs[4] = '{7'h00, 32'h12345678, 4'hF, 2'b10, 16'h0000, 32'hCAFE0001, 2'b00};
        vecs[5] = '{7'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 16'h0010, 32'h00000000, 2'b00};
        vecs[6] = '{7'h3F, 32'h5A5A0F0F, 4'hC, 2'b00, 16'h8000, 32'h5A5A0000, 2'b00};
        vecs[7] = '{7'h7C, 32'h0000FFFF, 4'hF, 2'b10, 16'h0000, 32'h00000000, 2'b10};
        vecs[8] = '{7'h06, 32'h77665544, 4'h6, 2'b00, 16'h0002, 32'hDE6655EF, 2'b00};

        for (int i = 0; i < NR; i++)
            I_RO_DATA[i*DW +: DW] = (i == 0) ? 32'hCAFE0001 : (32'hBAD00000 | i);

        S_AXI_ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b010; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b101; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (3) tick();
        S_AXI_ARESET = 1'b0;
        tick();

        // Reset state
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_reg_wr", O_REG_WR, 0);
        check("rst_regs_zero", O_REG_DATA == '0, 1);

        // Table: write then read back
        foreach (vecs[i]) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].bresp, vecs[i].wr);
            axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
        end
        check("ro_slice0_untouched", O_REG_DATA[0 +: DW], 0);
        check("reg1_slice", O_REG_DATA[1*DW +: DW], 32'hDE6655EF);
        check("reg15_slice", O_REG_DATA[15*DW +: DW], 32'h5A5A0000);

        // W three cycles ahead of AW; commit on the edge after the AW handshake
        bq.push_back(2'b00);
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        drive_hs(0, 1, 0);
        repeat (3) tick();
        check("wfirst_no_commit", S_AXI_BVALID, 0);
        S_AXI_AWADDR = 7'h08; S_AXI_AWVALID = 1'b1;
        drive_hs(1, 0, 0);
        check("wfirst_bvalid_early", S_AXI_BVALID, 0);
        tick();
        check("wfirst_bvalid", S_AXI_BVALID, 1);
        check("wfirst_reg_wr", O_REG_WR, 16'h0004);
        tick();
        axi_read(7'h08, 32'h11223344, 2'b00);

        // Commit and read of reg1 on the same edge: read sees the old value
        bq.push_back(2'b00);
        rq.push_back('{32'hDE6655EF, 2'b00});
        S_AXI_AWADDR = 7'h04; S_AXI_WDATA = 32'h01020304; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        drive_hs(1, 1, 0);
        S_AXI_ARADDR = 7'h04; S_AXI_ARVALID = 1'b1;
        drive_hs(0, 0, 1);
        check("same_edge_bvalid", S_AXI_BVALID, 1);
        tick();
        axi_read(7'h04, 32'h01020304, 2'b00);

        // BREADY low: B holds SLVERR with a new AW/W pending, then reset mid-hold
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 7'h00; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        drive_hs(1, 1, 0);
        tick();
        S_AXI_AWADDR = 7'h14; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("hold_awready", S_AXI_AWREADY, 0);
            check("hold_wready", S_AXI_WREADY, 0);
            check("hold_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b110);
            tick();
        end
        S_AXI_ARESET = 1'b1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        S_AXI_ARESET = 1'b0;
        check("mid_rst_bvalid", S_AXI_BVALID, 0);
        check("mid_rst_bresp", S_AXI_BRESP, 0);
        check("mid_rst_regs_zero", O_REG_DATA == '0, 1);
        check("mid_rst_reg_wr", O_REG_WR, 0);
        S_AXI_BREADY = 1'b1;
        tick();
        axi_read(7'h0C, 32'h0, 2'b00);

        repeat (3) tick();
        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
